clock_time_ctrl: RTL



---
 rtl/clock_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 63 ++++++
 rtl/clock_time_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the HH:MM:SS clock controller:
//   - FSM state encoding (the edit_field output reuses the same encoding)
//   - field widths and wrap limits
//   - wrap-around increment helpers for the hours and minutes/seconds fields
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int HOURS_W = 5;
    localparam int MIN_W   = 6;
    localparam int EDIT_W  = 2;

    localparam logic [HOURS_W-1:0] HOURS_MAX  = 5'd23;
    localparam logic [MIN_W-1:0]   MINSEC_MAX = 6'd59;

    // The numeric value of each state is also the edit_field code shown to the
    // pixel generator (0 = none, 1 = HH, 2 = MM, 3 = SS).
    typedef enum logic [EDIT_W-1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } state_e;

    function automatic logic [HOURS_W-1:0] hours_inc(input logic [HOURS_W-1:0] h);
        return (h == HOURS_MAX) ? '0 : h + HOURS_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] minsec_inc(input logic [MIN_W-1:0] v);
        return (v == MINSEC_MAX) ? '0 : v + MIN_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises an asynchronous push-button, debounces it and emits a one-cycle
// press pulse on each accepted rising edge of the debounced level.
//
// Ports:
//   clk    in   1  system clock
//   rst    in   1  synchronous reset, active-high
//   raw    in   1  asynchronous button level, 1 = pressed
//   press  out  1  one-cycle pulse per accepted press (releases give no pulse)
//
// A steady raw rise reaches press after DEBOUNCE_CYCLES+3 clocks:
// 2 synchroniser stages + DEBOUNCE_CYCLES counting cycles + 1 edge register.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_prev_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;

            // Any sample agreeing with the stable level restarts the count, so
            // only DEBOUNCE_CYCLES consecutive disagreeing samples flip it.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// -----------------------------------------------------------------------------
// clock_time_ctrl
// Timekeeping and user-set controller for the HH:MM:SS HDMI clock display.
// Owns the time registers and the 1 Hz prescaler, lets the user set the time
// with MODE/INC buttons, and presents frame-synchronous values to the pixel
// generator so digits never change mid-frame.
//
// Ports:
//   clk           in   1  user clock, sole clock domain
//   rst           in   1  synchronous reset, active-high
//   btn_mode_raw  in   1  MODE button, asynchronous, 1 = pressed
//   btn_inc_raw   in   1  INC button, asynchronous, 1 = pressed
//   frame_sof     in   1  one-cycle start-of-frame strobe
//   disp_hours    out  5  displayed hours 0-23 (frame-latched)
//   disp_minutes  out  6  displayed minutes 0-59 (frame-latched)
//   disp_seconds  out  6  displayed seconds 0-59 (frame-latched)
//   edit_field    out  2  0 = none, 1 = HH, 2 = MM, 3 = SS (frame-latched)
//   blink         out  1  blink phase, 1 = hide the edited field (not latched)
// -----------------------------------------------------------------------------
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ          = 27_000_000,
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int BLINK_HALF      = 6_750_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_mode_raw,
    input  logic               btn_inc_raw,
    input  logic               frame_sof,
    output logic [HOURS_W-1:0] disp_hours,
    output logic [MIN_W-1:0]   disp_minutes,
    output logic [MIN_W-1:0]   disp_seconds,
    output logic [EDIT_W-1:0]  edit_field,
    output logic               blink
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic mode_press;
    logic inc_press;
    logic inc_edit;
    logic tick;

    state_e             state_q;
    logic [PRESC_W-1:0] presc_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_q;

    logic [HOURS_W-1:0] hours_q,   hours_d;
    logic [MIN_W-1:0]   minutes_q, minutes_d;
    logic [MIN_W-1:0]   seconds_q, seconds_d;

    logic [HOURS_W-1:0] disp_hours_q;
    logic [MIN_W-1:0]   disp_minutes_q;
    logic [MIN_W-1:0]   disp_seconds_q;
    logic [EDIT_W-1:0]  disp_edit_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_mode_raw),
        .press(mode_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_inc_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_inc_raw),
        .press(inc_press)
    );

    // The prescaler only advances in RUN, so tick cannot fire while editing.
    assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

    // MODE wins over a coincident INC; INC is meaningless outside the set states.
    assign inc_edit = inc_press && !mode_press && (state_q != RUN);

    // Next time value: a running tick with carries, or a single-field edit
    // that wraps without touching its neighbours.
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        if (tick) begin
            seconds_d = minsec_inc(seconds_q);
            if (seconds_q == MINSEC_MAX) begin
                minutes_d = minsec_inc(minutes_q);
                if (minutes_q == MINSEC_MAX) begin
                    hours_d = hours_inc(hours_q);
                end
            end
        end else if (inc_edit) begin
            case (state_q)
                SET_HH:  hours_d   = hours_inc(hours_q);
                SET_MM:  minutes_d = minsec_inc(minutes_q);
                SET_SS:  seconds_d = minsec_inc(seconds_q);
                default: ;
            endcase
        end
    end

    // Control: mode FSM, prescaler and blink generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            if (mode_press) begin
                case (state_q)
                    RUN:     state_q <= SET_HH;
                    SET_HH:  state_q <= SET_MM;
                    SET_MM:  state_q <= SET_SS;
                    SET_SS:  state_q <= RUN;
                    default: state_q <= RUN;
                endcase
            end

            // Held at zero while editing, so leaving SET_SS restarts a full
            // second before the first tick.
            if ((state_q == RUN) && !mode_press) begin
                presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
            end else begin
                presc_q <= '0;
            end

            // Any press restarts the blink with the field visible, so the user
            // sees each edit immediately.
            if (mode_press || inc_press || (state_q == RUN)) begin
                blink_cnt_q <= '0;
                blink_q     <= 1'b0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Live time registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
        end else begin
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
        end
    end

    // Frame shadow: sampled once per frame so the pixel generator sees a
    // consistent time and edit field for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_hours_q   <= '0;
            disp_minutes_q <= '0;
            disp_seconds_q <= '0;
            disp_edit_q    <= '0;
        end else if (frame_sof) begin
            disp_hours_q   <= hours_q;
            disp_minutes_q <= minutes_q;
            disp_seconds_q <= seconds_q;
            disp_edit_q    <= state_q;
        end
    end

    assign disp_hours   = disp_hours_q;
    assign disp_minutes = disp_minutes_q;
    assign disp_seconds = disp_seconds_q;
    assign edit_field   = disp_edit_q;
    assign blink        = blink_q;

endmodule
